// File: rtl/alu_pkg.sv
// Shared definitions for the ALU packet parser: FSM states, legal opcodes and
// header geometry.
package alu_pkg;

    typedef enum logic [2:0] {
        ST_OPCODE  = 3'd0,
        ST_RSVD    = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_LEN_HI  = 3'd3,
        ST_COLLECT = 3'd4,
        ST_EMIT    = 3'd5,
        ST_DRAIN   = 3'd6
    } state_e;

    localparam logic [7:0]  OP_ADD  = 8'hA0;
    localparam logic [7:0]  OP_MUL  = 8'hA1;
    localparam logic [7:0]  OP_DIV  = 8'hA2;

    localparam logic [15:0] HDR_LEN = 16'd4;
    localparam logic [15:0] MIN_LEN = 16'd8;

    function automatic logic opcode_legal(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_operand_shift.sv
// Byte-to-word assembler: consecutive bytes fill lanes 0..N-1 of the operand
// (little-endian); word_done_o flags the byte that completes a word.
module alu_operand_shift #(
    parameter int datawidth_p = 8,
    parameter int opwidth_p   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   byte_valid_i,
    input  logic [datawidth_p-1:0] byte_i,
    output logic [opwidth_p-1:0]   operand_o,
    output logic                   word_done_o
);

    localparam int lanes_lp = opwidth_p / datawidth_p;
    localparam int idx_w_lp = $clog2(lanes_lp);

    logic [idx_w_lp-1:0]    idx_q, idx_d;
    logic [datawidth_p-1:0] lane_q [lanes_lp];
    logic [datawidth_p-1:0] lane_d [lanes_lp];

    always_comb begin
        idx_d = idx_q;
        if (byte_valid_i) begin
            idx_d = (idx_q == idx_w_lp'(lanes_lp - 1)) ? '0 : idx_q + idx_w_lp'(1);
        end
    end

    assign word_done_o = byte_valid_i && (idx_q == idx_w_lp'(lanes_lp - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < lanes_lp; gi++) begin : g_lane
            assign lane_d[gi] = (byte_valid_i && (idx_q == idx_w_lp'(gi))) ? byte_i : lane_q[gi];
            assign operand_o[gi*datawidth_p +: datawidth_p] = lane_q[gi];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    lane_q[gi] <= '0;
                end else begin
                    lane_q[gi] <= lane_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/alu_packet_parser.sv
// Parses opcode/length-framed packets from a byte stream into 32-bit operands
// for a downstream ALU; malformed packets are drained and flagged.
module alu_packet_parser
    import alu_pkg::*;
#(
    parameter int datawidth_p = 8,
    parameter int opwidth_p   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [datawidth_p-1:0] rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    output logic [datawidth_p-1:0] opcode_o,
    output logic [opwidth_p-1:0]   operand_o,
    output logic                   operand_valid_o,
    input  logic                   operand_ready_i,
    output logic                   operand_last_o,
    output logic                   frame_err_o
);

    state_e                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [datawidth_p-1:0] opc_hold_q, opc_hold_d;
    logic [datawidth_p-1:0] opcode_q, opcode_d;
    logic [datawidth_p-1:0] len_lo_q, len_lo_d;
    logic                   frame_err_q, frame_err_d;

    logic        accept;
    logic        collect_byte;
    logic        word_done;
    logic [15:0] len_w;
    logic        pkt_legal;

    // Ready depends only on registered state, never on operand_ready_i.
    assign rx_ready_o   = !rst_i && (state_q != ST_EMIT);
    assign accept       = rx_valid_i && rx_ready_o;
    assign collect_byte = accept && (state_q == ST_COLLECT);
    assign len_w        = {rx_data_i, len_lo_q};
    assign pkt_legal    = opcode_legal(opc_hold_q) && (len_w >= MIN_LEN) && (len_w[1:0] == 2'b00);

    alu_operand_shift #(
        .datawidth_p (datawidth_p),
        .opwidth_p   (opwidth_p)
    ) u_shift (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_valid_i (collect_byte),
        .byte_i       (rx_data_i),
        .operand_o    (operand_o),
        .word_done_o  (word_done)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opc_hold_d  = opc_hold_q;
        opcode_d    = opcode_q;
        len_lo_d    = len_lo_q;
        frame_err_d = 1'b0;
        case (state_q)
            ST_OPCODE: if (accept) begin
                opc_hold_d = rx_data_i;
                state_d    = ST_RSVD;
            end
            ST_RSVD: if (accept) begin
                state_d = ST_LEN_LO;
            end
            ST_LEN_LO: if (accept) begin
                len_lo_d = rx_data_i;
                state_d  = ST_LEN_HI;
            end
            ST_LEN_HI: if (accept) begin
                opcode_d = opc_hold_q;
                if (pkt_legal) begin
                    cnt_d   = len_w - HDR_LEN;
                    state_d = ST_COLLECT;
                end else begin
                    frame_err_d = 1'b1;
                    if (len_w > HDR_LEN) begin
                        cnt_d   = len_w - HDR_LEN;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_OPCODE;
                    end
                end
            end
            ST_COLLECT: if (accept) begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end
                if (word_done) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: if (operand_ready_i) begin
                state_d = (cnt_q != 16'd0) ? ST_COLLECT : ST_OPCODE;
            end
            ST_DRAIN: if (accept) begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end
                if (cnt_q <= 16'd1) begin
                    state_d = ST_OPCODE;
                end
            end
            default: state_d = ST_OPCODE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_OPCODE;
            cnt_q       <= '0;
            opc_hold_q  <= '0;
            opcode_q    <= '0;
            len_lo_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opc_hold_q  <= opc_hold_d;
            opcode_q    <= opcode_d;
            len_lo_q    <= len_lo_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign opcode_o        = opcode_q;
    assign frame_err_o     = frame_err_q;
    assign operand_valid_o = (state_q == ST_EMIT);
    assign operand_last_o  = (state_q == ST_EMIT) && (cnt_q == 16'd0);

endmodule
